// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD-line engine: receives and checks 48-bit host commands, then
// serialises an R1/R3 (48-bit) or R2 (136-bit) response with CRC7 built on the fly.
module sd_card_cmd_responder #(
   parameter int unsigned NCR       = 2,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic         sd_clock_i,
   input  logic         reset_ni,
   input  logic         enable_i,
   input  logic         cmd_in_i,
   input  logic [5:0]   resp_index_i,
   input  logic [31:0]  resp_arg_i,
   input  logic         resp_long_i,
   input  logic [119:0] resp_payload_i,
   output logic         cmd_out_o,
   output logic         cmd_oe_o,
   output logic         cmd_valid_o,
   output logic [5:0]   cmd_index_rx_o,
   output logic [31:0]  cmd_arg_rx_o,
   output logic         crc_error_o,
   output logic         busy_o
);

   typedef enum logic [2:0] {StIdle, StReceive, StCheck, StWaitNcr, StSend} state_e;

   localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] RxCrcEnd   = CNT_WIDTH'(40);
   localparam logic [CNT_WIDTH-1:0] RxLast     = CNT_WIDTH'(47);
   localparam logic [CNT_WIDTH-1:0] NcrLast    = CNT_WIDTH'(NCR - 1);
   localparam logic [CNT_WIDTH-1:0] ShortData  = CNT_WIDTH'(40);
   localparam logic [CNT_WIDTH-1:0] LongData   = CNT_WIDTH'(128);
   localparam logic [CNT_WIDTH-1:0] LongCrcLo  = CNT_WIDTH'(8);
   localparam logic [CNT_WIDTH-1:0] ShortTotal = CNT_WIDTH'(48);
   localparam logic [CNT_WIDTH-1:0] LongTotal  = CNT_WIDTH'(136);

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[6];
      return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
   endfunction

   state_e                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [46:0]            rx_q, rx_d;
   logic [6:0]             crc_q, crc_d;
   logic [127:0]           tx_q, tx_d;
   logic                   long_q, long_d;
   logic                   out_q, out_d;
   logic                   oe_q, oe_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;
   logic [5:0]             idx_q, idx_d;
   logic [31:0]            arg_q, arg_d;

   logic                   rx_good;
   logic [CNT_WIDTH-1:0]   send_data_end, send_crc_lo, send_total;

   // rx_q holds bits 46..0 of the frame; the start bit is implied by entering StReceive.
   assign rx_good       = rx_q[46] && rx_q[0] && (rx_q[7:1] == crc_q);
   assign send_data_end = long_q ? LongData : ShortData;
   assign send_crc_lo   = long_q ? LongCrcLo : '0;
   assign send_total    = long_q ? LongTotal : ShortTotal;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      crc_d   = crc_q;
      tx_d    = tx_q;
      long_d  = long_q;
      out_d   = out_q;
      oe_d    = oe_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      idx_d   = idx_q;
      arg_d   = arg_q;
      if (!enable_i) begin
         state_d = StIdle;
         cnt_d   = '0;
         oe_d    = 1'b0;
         out_d   = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!cmd_in_i) begin
                  state_d = StReceive;
                  cnt_d   = CntOne;
                  rx_d    = '0;
                  crc_d   = crc7_step(7'd0, cmd_in_i);
               end
            end
            StReceive: begin
               rx_d  = {rx_q[45:0], cmd_in_i};
               cnt_d = cnt_q + CntOne;
               if (cnt_q < RxCrcEnd) crc_d = crc7_step(crc_q, cmd_in_i);
               if (cnt_q == RxLast) state_d = StCheck;
            end
            StCheck: begin
               cnt_d = '0;
               if (rx_good) begin
                  valid_d = 1'b1;
                  idx_d   = rx_q[45:40];
                  arg_d   = rx_q[39:8];
                  // CMD0 (GO_IDLE_STATE) never gets a response.
                  if (rx_q[45:40] == 6'd0) state_d = StIdle;
                  else                     state_d = StWaitNcr;
               end else begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
            end
            StWaitNcr: begin
               if (cnt_q == NcrLast) begin
                  state_d = StSend;
                  cnt_d   = '0;
                  long_d  = resp_long_i;
                  crc_d   = '0;
                  tx_d    = resp_long_i ? {8'h3F, resp_payload_i}
                                        : {2'b00, resp_index_i, resp_arg_i, 88'd0};
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
            StSend: begin
               oe_d = 1'b1;
               if (cnt_q == send_total) begin
                  state_d = StIdle;
                  oe_d    = 1'b0;
                  out_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CntOne;
                  if (cnt_q < send_data_end) begin
                     out_d = tx_q[127];
                     tx_d  = {tx_q[126:0], 1'b0};
                     // R2 header (0,0,111111) is excluded from the CRC.
                     if (cnt_q >= send_crc_lo) crc_d = crc7_step(crc_q, tx_q[127]);
                  end else if (cnt_q < send_total - CntOne) begin
                     out_d = crc_q[6];
                     crc_d = {crc_q[5:0], 1'b0};
                  end else begin
                     out_d = 1'b1;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge sd_clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rx_q    <= '0;
         crc_q   <= '0;
         tx_q    <= '0;
         long_q  <= 1'b0;
         out_q   <= 1'b1;
         oe_q    <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         arg_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rx_q    <= rx_d;
         crc_q   <= crc_d;
         tx_q    <= tx_d;
         long_q  <= long_d;
         out_q   <= out_d;
         oe_q    <= oe_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         arg_q   <= arg_d;
      end
   end

   assign cmd_out_o      = out_q;
   assign cmd_oe_o       = oe_q;
   assign cmd_valid_o    = valid_q;
   assign crc_error_o    = err_q;
   assign cmd_index_rx_o = idx_q;
   assign cmd_arg_rx_o   = arg_q;
   assign busy_o         = (state_q != StIdle);

endmodule
